uart_rx: RTL

- Serial UART receiver. It is the receive-side counterpart of the team's 16x-oversampled UART transmitter.
- Samples the asynchronous rx line using the shared baud-rate s_tick strobe, which runs at 16 ticks per bit.
- Recovers one frame: start bit, DBIT data bits LSB-first, stop bit(s).
- Presents each completed byte with a one-cycle done pulse and a framing-error flag to the downstream FIFO or command logic.

---
 rtl/uart_rx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver.
// Recovers start/DBIT data/stop, flags framing errors, pulses done per frame.

module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int         SH     = 8 - DBIT;
  localparam logic [4:0] S_MID  = 5'd7;
  localparam logic [4:0] S_BIT  = 5'd15;
  localparam logic [4:0] S_STOP = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST = 3'(DBIT - 1);

  state_t     state_q, state_d;
  logic [4:0] s_q, s_d;
  logic [2:0] n_q, n_d;
  logic [7:0] b_q, b_d;
  logic       rx_m, rx_s;
  logic [7:0] dout_d;
  logic       done_d;
  logic       ferr_d;

  // two-flop synchronizer, idles high so reset never looks like a start
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout         <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      dout         <= dout_d;
      frame_err    <= ferr_d;
      rx_done_tick <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout;
    ferr_d  = frame_err;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            // a high line at mid start bit is a glitch
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {rx_s, b_q[7:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            state_d = IDLE;
            dout_d  = b_q >> SH;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
